// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe
// Purpose  : Pipelined RV32I decode stage. Holds one decoded instruction
//            between fetch and execute with valid/ready handshakes on both
//            sides, detects load-use hazards, honours flushes, redirects
//            fetch early on JAL and keeps saturating stall/flush counters.
// Ports    : clock, reset                      - clock, sync active-high reset
//            in_valid/in_ready/in_PC/
//            in_instruction                    - fetch side handshake
//            flush                             - kill stage contents
//            ex_valid/ex_is_load/ex_rd         - load currently in execute
//            out_valid/out_ready               - execute side handshake
//            PC, read_sel1/2, write_sel, wEn, mem_wEn, wb_sel, branch_op,
//            op_B_sel, op_A_sel, ALU_Control,
//            imm32, illegal                    - registered decode bundle
//            redirect/redirect_PC              - one-cycle JAL redirect
//            stall_count/flush_count           - saturating counters
// Revision : 1.0 - initial pipelined release
// ============================================================================
module decode_pipe #(
  parameter int          ADDRESS_BITS = 16,
  parameter int          CNT_BITS     = 16,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_PC,
  input  logic [31:0]             in_instruction,
  input  logic                    flush,
  input  logic                    ex_valid,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic                    branch_op,
  output logic                    op_B_sel,
  output logic [1:0]              op_A_sel,
  output logic [5:0]              ALU_Control,
  output logic [31:0]             imm32,
  output logic                    illegal,
  output logic                    redirect,
  output logic [ADDRESS_BITS-1:0] redirect_PC,
  output logic [CNT_BITS-1:0]     stall_count,
  output logic [CNT_BITS-1:0]     flush_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Everything that is registered into the output bundle.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        mem_wen;
    logic        wb_sel;
    logic        branch_op;
    logic        op_b_sel;
    logic [1:0]  op_a_sel;
    logic [5:0]  alu_ctrl;
    logic [31:0] imm;
    logic        illegal;
  } fields_t;

  function automatic fields_t decode(input logic [31:0] ins);
    fields_t    d;
    logic [2:0] f3;
    logic [1:0] cls;
    logic       alt;
    d     = '0;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    f3    = ins[14:12];
    cls   = 2'b00;
    alt   = 1'b0;
    case (ins[6:0])
      OPC_OP: begin
        alt   = ins[30];
        d.wen = 1'b1;
      end
      OPC_OPIMM: begin
        // Only the shift-right immediates carry an alternate encoding.
        alt        = (f3 == 3'b101) & ins[30];
        d.wen      = 1'b1;
        d.op_b_sel = 1'b1;
        d.imm      = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LOAD: begin
        cls        = 2'b10;
        f3         = 3'b000;
        d.wen      = 1'b1;
        d.wb_sel   = 1'b1;
        d.op_b_sel = 1'b1;
        d.imm      = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        cls        = 2'b10;
        f3         = 3'b000;
        d.mem_wen  = 1'b1;
        d.op_b_sel = 1'b1;
        d.imm      = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        cls         = 2'b01;
        d.branch_op = 1'b1;
        d.imm       = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_LUI: begin
        cls        = 2'b10;
        f3         = 3'b000;
        d.wen      = 1'b1;
        d.op_a_sel = 2'b11;
        d.op_b_sel = 1'b1;
        d.imm      = {ins[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        cls        = 2'b10;
        f3         = 3'b000;
        d.wen      = 1'b1;
        d.op_a_sel = 2'b01;
        d.op_b_sel = 1'b1;
        d.imm      = {ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        cls        = 2'b11;
        d.wen      = 1'b1;
        d.op_a_sel = 2'b01;
        d.op_b_sel = 1'b1;
        d.imm      = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        cls        = 2'b11;
        d.wen      = 1'b1;
        d.op_b_sel = 1'b1;
        d.imm      = {{20{ins[31]}}, ins[31:20]};
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    if (d.rd == 5'd0) begin
      d.wen = 1'b0;
    end
    d.alu_ctrl = {cls, alt, f3};
    return d;
  endfunction

  fields_t in_dec;
  fields_t nop_dec;
  fields_t reset_dec;
  fields_t stage;

  logic                    use_rs1;
  logic                    use_rs2;
  logic                    is_jal;
  logic                    hazard;
  logic                    accept;
  logic [ADDRESS_BITS-1:0] jal_target;
  logic                    out_valid_q;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic                    redirect_q;
  logic [ADDRESS_BITS-1:0] redirect_pc_q;
  logic [CNT_BITS-1:0]     stall_q;
  logic [CNT_BITS-1:0]     flush_q;

  assign in_dec  = decode(in_instruction);
  assign nop_dec = decode(NOP_INSTR);

  // Reset shows the NOP decode but with all control strobes and the
  // immediate cleared, so nothing downstream can mistake it for real work.
  always_comb begin
    reset_dec           = nop_dec;
    reset_dec.wen       = 1'b0;
    reset_dec.mem_wen   = 1'b0;
    reset_dec.wb_sel    = 1'b0;
    reset_dec.branch_op = 1'b0;
    reset_dec.op_b_sel  = 1'b0;
    reset_dec.illegal   = 1'b0;
    reset_dec.imm       = 32'd0;
  end

  // Register usage: only these opcodes can create a load-use dependency.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_jal  = 1'b0;
    case (in_instruction[6:0])
      OPC_OP, OPC_BRANCH, OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        use_rs1 = 1'b1;
      end
      OPC_JAL: begin
        is_jal = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
      end
    endcase
  end

  assign hazard = in_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                  ((use_rs1 & (in_dec.rs1 == ex_rd)) |
                   (use_rs2 & (in_dec.rs2 == ex_rd)));

  assign in_ready   = ~reset & ~flush & ~hazard & (~out_valid_q | out_ready);
  assign accept     = in_valid & in_ready;
  assign jal_target = in_PC + in_dec.imm[ADDRESS_BITS-1:0];

  // Priority: reset, flush, accept, drain to bubble, hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      stage         <= reset_dec;
      pc_q          <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      if (flush) begin
        out_valid_q <= 1'b0;
        stage       <= nop_dec;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        stage       <= in_dec;
        pc_q        <= in_PC;
        if (is_jal) begin
          redirect_q    <= 1'b1;
          redirect_pc_q <= jal_target;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        stage       <= nop_dec;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign PC          = pc_q;
  assign read_sel1   = stage.rs1;
  assign read_sel2   = stage.rs2;
  assign write_sel   = stage.rd;
  assign wEn         = stage.wen;
  assign mem_wEn     = stage.mem_wen;
  assign wb_sel      = stage.wb_sel;
  assign branch_op   = stage.branch_op;
  assign op_B_sel    = stage.op_b_sel;
  assign op_A_sel    = stage.op_a_sel;
  assign ALU_Control = stage.alu_ctrl;
  assign imm32       = stage.imm;
  assign illegal     = stage.illegal;
  assign redirect    = redirect_q;
  assign redirect_PC = redirect_pc_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_pipe
// Purpose  : Directed self-checking bench for decode_pipe. A second instance
//            with 2-bit counters shares the stimulus to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

  localparam int AB = 16;

  localparam logic [31:0] ADDI_A1  = 32'hFFF00593; // addi a1,zero,-1
  localparam logic [31:0] ADD_A6   = 32'h00C58833; // add a6,a1,a2
  localparam logic [31:0] SW_A2    = 32'h00C5A023; // sw a2,0(a1)
  localparam logic [31:0] BEQ_A1   = 32'h00C58063; // beq a1,a2,0
  localparam logic [31:0] JAL_I    = 32'h0140006F; // jal zero,+0x14
  localparam logic [31:0] ILL_I    = 32'h00000FFF; // opcode 0x7F, rd=31
  localparam logic [31:0] SRAI_I   = 32'h40315093; // srai x1,x2,3

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [AB-1:0] in_PC;
  logic [31:0]   in_instruction;
  logic          flush;
  logic          ex_valid;
  logic          ex_is_load;
  logic [4:0]    ex_rd;
  logic          out_ready;

  logic          in_ready, out_valid, wEn, mem_wEn, wb_sel, branch_op, op_B_sel;
  logic          illegal, redirect;
  logic [AB-1:0] PC, redirect_PC;
  logic [4:0]    read_sel1, read_sel2, write_sel;
  logic [1:0]    op_A_sel;
  logic [5:0]    ALU_Control;
  logic [31:0]   imm32;
  logic [15:0]   stall_count, flush_count;

  logic          in_ready2, out_valid2, wEn2, mem_wEn2, wb_sel2, branch_op2, op_B_sel2;
  logic          illegal2, redirect2;
  logic [AB-1:0] PC2, redirect_PC2;
  logic [4:0]    read_sel12, read_sel22, write_sel2;
  logic [1:0]    op_A_sel2;
  logic [5:0]    ALU_Control2;
  logic [31:0]   imm322;
  logic [1:0]    stall_count2, flush_count2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  decode_pipe #(.ADDRESS_BITS(AB), .CNT_BITS(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_PC(in_PC), .in_instruction(in_instruction), .flush(flush),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .PC(PC),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
    .wEn(wEn), .mem_wEn(mem_wEn), .wb_sel(wb_sel), .branch_op(branch_op),
    .op_B_sel(op_B_sel), .op_A_sel(op_A_sel), .ALU_Control(ALU_Control),
    .imm32(imm32), .illegal(illegal), .redirect(redirect),
    .redirect_PC(redirect_PC), .stall_count(stall_count), .flush_count(flush_count)
  );

  decode_pipe #(.ADDRESS_BITS(AB), .CNT_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_PC(in_PC), .in_instruction(in_instruction), .flush(flush),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .out_valid(out_valid2), .out_ready(out_ready), .PC(PC2),
    .read_sel1(read_sel12), .read_sel2(read_sel22), .write_sel(write_sel2),
    .wEn(wEn2), .mem_wEn(mem_wEn2), .wb_sel(wb_sel2), .branch_op(branch_op2),
    .op_B_sel(op_B_sel2), .op_A_sel(op_A_sel2), .ALU_Control(ALU_Control2),
    .imm32(imm322), .illegal(illegal2), .redirect(redirect2),
    .redirect_PC(redirect_PC2), .stall_count(stall_count2), .flush_count(flush_count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] ins, input logic [AB-1:0] pc);
    in_valid       = v;
    in_instruction = ins;
    in_PC          = pc;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_PC = '0; in_instruction = 32'h0;
    flush = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    out_ready = 1'b1;
    tick(); tick();
    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_redirect", redirect, 0);
    check("rst_PC", PC, 0);
    check("rst_imm32", imm32, 0);
    check("rst_op_B_sel", op_B_sel, 0);
    check("rst_stall", stall_count, 0);
    check("rst_flush", flush_count, 0);
    reset = 1'b0;

    // Streaming two instructions back to back
    offer(1, ADDI_A1, 16'h0100);
    #1 check("s1_in_ready", in_ready, 1);
    tick();
    check("s1_out_valid", out_valid, 1);
    check("s1_imm32", imm32, 32'hFFFFFFFF);
    check("s1_write_sel", write_sel, 11);
    check("s1_wEn", wEn, 1);
    check("s1_PC", PC, 16'h0100);
    offer(1, ADD_A6, 16'h0104);
    tick();
    check("s2_out_valid", out_valid, 1);
    check("s2_alu", ALU_Control, 6'b000000);
    check("s2_op_B_sel", op_B_sel, 0);
    check("s2_write_sel", write_sel, 16);
    check("s2_read_sel2", read_sel2, 12);
    offer(0, 32'h0, 16'h0);
    tick();
    check("bub_out_valid", out_valid, 0);
    check("bub_write_sel", write_sel, 0);
    check("bub_op_B_sel", op_B_sel, 1);

    // Load-use hazard on a1
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd11;
    offer(1, ADD_A6, 16'h0104);
    #1 check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_out_valid", out_valid, 0);
    check("lu_stall", stall_count, 1);
    ex_valid = 0;
    #1 check("lu_in_ready_after", in_ready, 1);
    tick();
    check("lu_accept_valid", out_valid, 1);
    check("lu_accept_rd", write_sel, 16);
    check("lu_stall_hold", stall_count, 1);

    // Replace in flight bundle, then backpressure
    offer(1, SW_A2, 16'h0108);
    tick();
    check("sw_valid", out_valid, 1);
    check("sw_mem_wEn", mem_wEn, 1);
    out_ready = 0;
    offer(1, BEQ_A1, 16'h010C);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_PC", PC, 16'h0108);
      check("bp_mem_wEn", mem_wEn, 1);
      check("bp_wEn", wEn, 0);
      check("bp_read_sel2", read_sel2, 12);
    end
    out_ready = 1;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    check("beq_valid", out_valid, 1);
    check("beq_branch_op", branch_op, 1);
    check("beq_op_B_sel", op_B_sel, 0);
    check("beq_PC", PC, 16'h010C);

    // Flush while holding the branch
    out_ready = 0; offer(0, 32'h0, 16'h0); flush = 1;
    #1 check("fl_in_ready", in_ready, 0);
    tick();
    check("fl_out_valid", out_valid, 0);
    check("fl_count", flush_count, 1);
    flush = 0; out_ready = 1;

    // JAL redirect
    offer(1, JAL_I, 16'h0114);
    tick();
    check("jal_valid", out_valid, 1);
    check("jal_redirect", redirect, 1);
    check("jal_target", redirect_PC, 16'h0128);
    check("jal_op_A_sel", op_A_sel, 2'b01);
    check("jal_alu", ALU_Control, 6'b110000);
    offer(0, 32'h0, 16'h0);
    tick();
    check("jal_pulse_end", redirect, 0);
    // JAL with simultaneous flush
    offer(1, JAL_I, 16'h0114); flush = 1;
    #1 check("jalfl_in_ready", in_ready, 0);
    tick();
    check("jalfl_redirect", redirect, 0);
    check("jalfl_valid", out_valid, 0);
    check("jalfl_count", flush_count, 2);
    flush = 0;

    // Illegal opcode, then srai
    offer(1, ILL_I, 16'h0120);
    tick();
    check("ill_illegal", illegal, 1);
    check("ill_wEn", wEn, 0);
    check("ill_mem_wEn", mem_wEn, 0);
    offer(1, SRAI_I, 16'h0124);
    tick();
    check("srai_alu", ALU_Control, 6'b001101);
    check("srai_imm", imm32, 32'h00000403);
    check("srai_illegal", illegal, 0);
    check("srai_write_sel", write_sel, 1);

    // Counter saturation on the 2-bit instance
    offer(0, 32'h0, 16'h0); flush = 1;
    tick(); tick(); tick();
    check("sat_wide", flush_count, 5);
    check("sat_narrow", flush_count2, 3);
    check("sat_stall_narrow", stall_count2, 1);

    // Reset overrides flush
    reset = 1;
    tick();
    check("rst2_flush", flush_count, 0);
    check("rst2_stall", stall_count, 0);
    check("rst2_valid", out_valid, 0);
    reset = 0; flush = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_pipe.md
# decode_pipe

Pipelined, parametrised successor to the single-cycle RV32I decode unit. It registers one decoded instruction between fetch and execute using valid/ready handshakes on both sides. It detects load-use hazards against the instruction in execute, honours flushes from branch/JALR resolution, and redirects fetch early on JAL. Saturating performance counters report stall and flush activity.

## Interface
- ADDRESS_BITS, 16: PC and target width.
- CNT_BITS, 16: width of each performance counter.
- NOP_INSTR, 32'h00000013: instruction substituted when the stage is empty (addi zero, zero, 0).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_PC  in  ADDRESS_BITS  PC of the offered instruction.
- in_instruction  in  32  raw instruction.
- flush  in  1  branch/JALR redirect from execute; kills the stage contents.
- ex_valid, ex_is_load  in  1 each  execute holds a valid load.
- ex_rd  in  5  destination register of that load.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- PC  out  ADDRESS_BITS  registered PC.
- read_sel1, read_sel2, write_sel  out  5 each  rs1, rs2, rd.
- wEn, mem_wEn, wb_sel, branch_op, op_B_sel  out  1 each  decoded controls.
- op_A_sel  out  2  operand A select: 00 = rs1, 01 = PC, 11 = zero.
- ALU_Control  out  6  {cls[1:0], alt, funct3}.
- imm32  out  32  sign-extended immediate.
- illegal  out  1  unsupported opcode.
- redirect  out  1  one-cycle JAL redirect pulse.
- redirect_PC  out  ADDRESS_BITS  JAL target.
- stall_count, flush_count  out  CNT_BITS each  saturating counters.

## Operation
**Decode (combinational, from `in_instruction`)**
- Immediates follow the standard RV32I I/S/B/U/J formats, sign-extended to 32 bits.
- `cls` values:
  - 00: OP / OP-IMM.
  - 01: branch.
  - 10: add-class (load, store, LUI, AUIPC; funct3 forced to 000).
  - 11: link (JAL/JALR; ALU produces PC+4).
- `alt` = funct7[5] for R-type and for OP-IMM with funct3=101; otherwise 0.
- Operand A: LUI selects zero (11); AUIPC and JAL select PC (01); all others select rs1 (00).
- `op_B_sel` = 1 for every format except R-type and branch.
- `wEn` = 0 for store, branch, illegal, and rd=0.
- `mem_wEn` = 1 only for a legal store.
- `wb_sel` = 1 only for load.
- `illegal` opcodes force `wEn` = 0 and `mem_wEn` = 0.

**Register usage**
- R-type, branch, store: use rs1 and rs2.
- OP-IMM, load, JALR: use rs1 only.
- LUI, AUIPC, JAL: use neither.

**Hazard and handshake**
- `hazard` = in_valid & ex_valid & ex_is_load & (ex_rd != 0) & ex_rd matches a used rs.
- in_ready = ~reset & ~flush & ~hazard & (~out_valid | out_ready).
- Accept (in_valid & in_ready): load all output registers; out_valid <= 1.
- Otherwise, if out_ready: out_valid <= 0 (bubble); a hazard inserts exactly this bubble.
- Otherwise the outputs hold, stable and unchanged.
- While the stage is empty, the output fields show the decode of NOP_INSTR.

**Flush**
- Highest priority: out_valid <= 0, the offered instruction is dropped, and a pending redirect is cancelled.

**JAL redirect**
- Accepting a JAL sets redirect = 1 for exactly the next cycle, with redirect_PC = in_PC + imm_J (truncated to ADDRESS_BITS).

**Counters**
- stall_count increments every cycle `hazard` = 1.
- flush_count increments every cycle `flush` = 1.
- Both saturate at all-ones.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Full throughput: 1 instruction/cycle when out_ready is held high.
- Reset values:
  - out_valid, redirect, illegal, wEn, mem_wEn, wb_sel, branch_op, op_B_sel: 0.
  - counters: 0; PC, redirect_PC, imm32: 0.
  - Other fields: NOP_INSTR decode.
- Reset takes effect on the next edge and is valid mid-stall; it overrides flush.
- Simultaneous out_ready and accept: the new bundle replaces the old one in the same edge, with no bubble.
- A flush together with an accepting condition results in no accept.
- A hazard together with out_valid & ~out_ready: hold, with stall_count still incrementing.

## Test plan
- Reset, then stream addi a1,zero,-1 and add a6,a1,a2 with out_ready=1: out_valid=1 on cycles 1 and 2; imm32=FFFFFFFF; second bundle ALU_Control=000000, op_B_sel=0, write_sel=16.
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=11, offer add a6,a1,a2: in_ready=0 for 1 cycle, one bubble, stall_count=1, accepted the next cycle once ex_valid=0.
- Backpressure: out_ready=0 for 3 cycles with sw a2,0(a1) held: outputs stable, mem_wEn=1, wEn=0, in_ready=0 throughout.
- JAL at in_PC=0x0114, instruction 0x0140006F: redirect=1 for one cycle, redirect_PC=0x0128; op_A_sel=01; a flush in the same cycle suppresses redirect.
- Flush while holding beq a1,a2: out_valid=0 next cycle and flush_count=1; with CNT_BITS=2, four flushes leave flush_count=3.
- Opcode 0x7F: illegal=1, wEn=0, mem_wEn=0; srai x1,x2,3 gives ALU_Control=001101, imm32=0x403.
